// File: rtl/trace_capture_mp_ram.sv
// trace_capture_mp_ram
//   Lookahead multiport RAM for the trace capture path: one byte-enabled
//   write port and NUM_RD independent read ports with one cycle of read
//   latency. A read that collides with a same-edge write returns the
//   post-write word, merged per byte. A clear sequencer zeroes the array,
//   either after reset (CLEAR_ON_RESET=1) or on a clear pulse, and holds
//   off writers through wr_waitrequest while it runs.
//
// Ports
//   clk, reset_n      clock; asynchronous active-low reset
//   wr_address        write word address
//   wr_writedata      write data
//   wr_byteenable     per-byte write enable (bit i -> bits [8i+7:8i])
//   wr_write          write strobe; accepted only while wr_waitrequest=0
//   wr_waitrequest    high while in reset or clearing
//   clear             single-cycle request to zero the array
//   rd_address        packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_readdata       packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
module trace_capture_mp_ram #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          wr_address,
  input  logic [DATA_WIDTH-1:0]          wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]        wr_byteenable,
  input  logic                           wr_write,
  output logic                           wr_waitrequest,
  input  logic                           clear,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_address,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_readdata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEARING,
    ST_READY
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEARING : ST_READY;
  localparam logic [ADDR_WIDTH-1:0] RESET_CNT = (CLEAR_ON_RESET != 0) ? LAST_ADDR : '0;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clearing;
  logic                    wr_accept;
  logic                    wr_in_range;

  logic [ADDR_WIDTH-1:0]   rd_addr     [NUM_RD];
  logic                    rd_in_range [NUM_RD];
  logic [NUM_RD-1:0]       rd_hit;

  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [DATA_WIDTH-1:0]   rd_word_q   [NUM_RD];
  logic [BE_WIDTH-1:0]     hit_mask_q  [NUM_RD];

  always_comb begin
    clearing    = (state == ST_CLEARING);
    wr_accept   = wr_write && !wr_waitrequest;
    wr_in_range = ({1'b0, wr_address} < DEPTH_LIM);
    rd_hit      = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_addr[p]     = rd_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_in_range[p] = ({1'b0, rd_addr[p]} < DEPTH_LIM);
      // A discarded out-of-range write must not leak into a read of the
      // same out-of-range address, so the hit also needs an in-range write.
      rd_hit[p]      = wr_accept && wr_in_range && (rd_addr[p] == wr_address);
    end
  end

  // Clear sequencer. wr_waitrequest is registered alongside the state so it
  // falls on the same edge that retires the address-0 clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RESET_STATE;
      clr_cnt        <= RESET_CNT;
      wr_waitrequest <= 1'b1;
    end else if (state == ST_CLEARING) begin
      if (clr_cnt == '0) begin
        state          <= ST_READY;
        wr_waitrequest <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt - 1'b1;
      end
    end else begin
      if (clear) begin
        state          <= ST_CLEARING;
        clr_cnt        <= LAST_ADDR;
        wr_waitrequest <= 1'b1;
      end else begin
        wr_waitrequest <= 1'b0;
      end
    end
  end

  // Storage array, not reset. Clearing and accepted writes never coincide
  // because wr_waitrequest is high for every clearing cycle.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept && wr_in_range) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (wr_byteenable[b]) begin
          mem[wr_address][8*b +: 8] <= wr_writedata[8*b +: 8];
        end
      end
    end
  end

  // Read registers: the array word is sampled before the same-edge write,
  // and the bypass mask records which bytes that write replaces.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_data_q <= '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        rd_word_q[p]  <= '0;
        hit_mask_q[p] <= '0;
      end
    end else begin
      wr_data_q <= wr_writedata;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (clearing || !rd_in_range[p]) begin
          rd_word_q[p] <= '0;
        end else begin
          rd_word_q[p] <= mem[rd_addr[p]];
        end
        hit_mask_q[p] <= rd_hit[p] ? wr_byteenable : '0;
      end
    end
  end

  // Per-byte bypass merge, fed only from registers.
  always_comb begin
    rd_readdata = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        rd_readdata[p*DATA_WIDTH + 8*b +: 8] = hit_mask_q[p][b] ? wr_data_q[8*b +: 8]
                                                                : rd_word_q[p][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_mp_ram.sv
// Testbench for trace_capture_mp_ram: two instances (DEPTH=16 and DEPTH=12)
// driven by identical stimulus, each checked against a word-level model.
module tb_trace_capture_mp_ram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  wr_address = '0;
  logic [31:0] wr_writedata = '0;
  logic [3:0]  wr_byteenable = '0;
  logic        wr_write = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  rd_address = '0;
  logic        wr_wait16, wr_wait12;
  logic [63:0] rd_data16, rd_data12;

  always #5 clk = ~clk;

  trace_capture_mp_ram #(
    .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .NUM_RD(2), .CLEAR_ON_RESET(1)
  ) u_dut16 (
    .clk(clk), .reset_n(reset_n),
    .wr_address(wr_address), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_write(wr_write),
    .wr_waitrequest(wr_wait16), .clear(clear),
    .rd_address(rd_address), .rd_readdata(rd_data16)
  );

  trace_capture_mp_ram #(
    .DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4), .NUM_RD(2), .CLEAR_ON_RESET(1)
  ) u_dut12 (
    .clk(clk), .reset_n(reset_n),
    .wr_address(wr_address), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_write(wr_write),
    .wr_waitrequest(wr_wait12), .clear(clear),
    .rd_address(rd_address), .rd_readdata(rd_data12)
  );

  typedef struct packed {
    logic        wait_req;
    logic [63:0] rd;
  } exp_t;

  exp_t q16[$];
  exp_t q12[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-instance word array, remaining busy cycles.
  // Entering a clear zeroes the whole array at once; reads during the
  // clear are defined as zero and writes are held off, so the order in
  // which the hardware walks the addresses is not observable.
  logic [31:0] m_mem  [2][16];
  int          m_busy [2];
  int          m_dep  [2] = '{16, 12};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit wr, input logic [3:0] wa,
                            input logic [31:0] wd, input logic [3:0] be, input bit clr,
                            input logic [3:0] ra0, input logic [3:0] ra1);
    exp_t e;
    bit   busy;
    int   a;
    logic [3:0] ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    e = '0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      m_busy[k] = m_dep[k];
      e.wait_req = 1'b1;
    end else begin
      busy = (m_busy[k] > 0);
      if (wr && !busy && int'(wa) < m_dep[k]) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[k][wa][8*b +: 8] = wd[8*b +: 8];
      end
      for (int p = 0; p < 2; p++) begin
        a = int'(ra[p]);
        if (!busy && a < m_dep[k]) e.rd[32*p +: 32] = m_mem[k][a];
      end
      if (busy) begin
        m_busy[k]--;
      end else if (clr) begin
        for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
        m_busy[k] = m_dep[k];
      end
      e.wait_req = (m_busy[k] > 0);
    end
    if (k == 0) q16.push_back(e);
    else        q12.push_back(e);
  endtask

  // Drives one cycle of inputs for the coming edge and queues the expected
  // outputs that edge should produce.
  task automatic step(input bit rst, input bit wr, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit clr, input logic [3:0] ra0,
                      input logic [3:0] ra1);
    @(posedge clk);
    #3;
    reset_n       = rst;
    wr_write      = wr;
    wr_address    = wa;
    wr_writedata  = wd;
    wr_byteenable = be;
    clear         = clr;
    rd_address    = {ra1, ra0};
    model_step(0, rst, wr, wa, wd, be, clr, ra0, ra1);
    model_step(1, rst, wr, wa, wd, be, clr, ra0, ra1);
  endtask

  task automatic idle(input int n, input logic [3:0] ra0, input logic [3:0] ra1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, ra0, ra1);
  endtask

  task automatic wr_only(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
    step(1'b1, 1'b1, wa, wd, be, 1'b0, 4'd0, 4'd0);
  endtask

  // Monitor: outputs are presented every cycle, so one expectation per
  // instance is retired just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check("wait16", {63'd0, wr_wait16}, {63'd0, e.wait_req});
        check("rd16", rd_data16, e.rd);
      end
      if (q12.size() > 0) begin
        e = q12.pop_front();
        check("wait12", {63'd0, wr_wait12}, {63'd0, e.wait_req});
        check("rd12", rd_data12, e.rd);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] wa, ra0, ra1, be;
    logic [31:0] wd;
    bit wr, clr, rst;

    // Reset, then post-reset clear window with reads, then all addresses.
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd1, 32'h1234_5678, 4'hF, 1'b0, 4'd1, 4'd2);
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b1, 4'(i), 32'hCAFE_0000 + 32'(i), 4'hF, 1'b1, 4'(i), 4'(15 - i));
    for (int i = 0; i < 16; i++) idle(1, 4'(i), 4'(15 - i));

    // Full write then read on both ports one cycle later.
    wr_only(4'd3, 32'hDEAD_BEEF, 4'hF);
    idle(2, 4'd3, 4'd3);

    // Same-edge partial-write bypass on port 0, neighbour read on port 1.
    wr_only(4'd5, 32'h1122_3344, 4'hF);
    wr_only(4'd6, 32'h5566_7788, 4'hF);
    step(1'b1, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, 4'd5, 4'd6);
    idle(1, 4'd5, 4'd6);

    // Clear pulse, write attempted during the clear, then read address 2.
    wr_only(4'd2, 32'h0F0F_0F0F, 4'hF);
    step(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 4'd3);
    step(1'b1, 1'b1, 4'd2, 32'h7777_7777, 4'hF, 1'b0, 4'd2, 4'd2);
    idle(16, 4'd2, 4'd5);

    // Reset in the middle of a clear restarts the full sequence.
    step(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0, 4'd1);
    idle(7, 4'd0, 4'd1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 4'd1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 4'd1);
    idle(18, 4'd4, 4'd9);

    // Out-of-range write and read on the DEPTH=12 instance.
    for (int i = 0; i < 12; i++) wr_only(4'(i), 32'hA5A5_0000 + 32'(i), 4'hF);
    step(1'b1, 1'b1, 4'd13, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd13, 4'd12);
    idle(1, 4'd13, 4'd11);
    for (int i = 0; i < 12; i++) idle(1, 4'(i), 4'(11 - i));

    // Randomised traffic with occasional clear and rare reset.
    for (int i = 0; i < 2000; i++) begin
      wr  = ($urandom_range(0, 1) == 1);
      wa  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      be  = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) != 0);
      // Bias reads towards the write address to exercise the bypass.
      ra0 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      step(rst, wr, wa, wd, be, clr, ra0, ra1);
    end
    idle(2, 4'd0, 4'd0);

    @(posedge clk);
    #2;
    check("drain", 64'(q16.size() + q12.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_capture_mp_ram.md
Name: trace_capture_mp_ram

Overview:
Parametrised lookahead multiport RAM for the trace capture path. It has one write port with byte enables and NUM_RD independent read ports, each with 1-cycle registered read latency. Same-cycle read/write collisions are bypassed, merged per byte, so readers always see the latest data. An optional clear-on-reset sequencer and a run-time clear request zero the array while holding off writers through wr_waitrequest.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
DEPTH, 16, number of words; need not be a power of 2
ADDR_WIDTH, 4, address width; requires 2**ADDR_WIDTH >= DEPTH
NUM_RD, 2, number of read ports (1..8)
CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = contents undefined after reset

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
wr_address  in  ADDR_WIDTH  write word address
wr_writedata  in  DATA_WIDTH  write data
wr_byteenable  in  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i]
wr_write  in  1  write strobe
wr_waitrequest  out  1  high = write not accepted (reset or clear in progress)
clear  in  1  single-cycle request to zero the whole array
rd_address  in  NUM_RD*ADDR_WIDTH  read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_readdata  out  NUM_RD*DATA_WIDTH  read data; port p uses slice [p*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset values: wr_waitrequest=1; all rd_readdata=0; bypass registers=0; clear counter=DEPTH-1 if CLEAR_ON_RESET=1, else 0. The array itself is not reset.
- Sequencer states: CLEARING and READY.
  - Reset enters CLEARING if CLEAR_ON_RESET=1, otherwise READY.
  - In READY, wr_waitrequest=0.
  - READY->CLEARING when clear=1 is sampled; the counter loads DEPTH-1.
- CLEARING:
  - writes 0 to mem[counter] every cycle and decrements the counter.
  - After the cycle that writes address 0, moves to READY; wr_waitrequest falls on that edge.
  - Total busy time is exactly DEPTH cycles.
  - clear asserted while CLEARING is ignored (no restart).
  - reset_n asserted mid-clear restarts per the reset rules above.
- With CLEAR_ON_RESET=0, wr_waitrequest falls on the first clk edge after reset release.
- Write acceptance: a write is accepted when wr_write=1 and wr_waitrequest=0 at the edge. Only bytes with byteenable=1 are updated. wr_write while waitrequest=1 is dropped with no side effects.
- Out-of-range addresses (>= DEPTH):
  - an accepted write to one is discarded;
  - a read of one returns 0 one cycle later.
- Read port p: address sampled at edge n; rd_readdata slice is valid from edge n to edge n+1 and holds until the next edge. Ports are fully independent, and all ports may read the same address.
- Memory read is read-before-write: the array value is taken before the same-edge write.
- Lookahead bypass, per port, registered at edge n:
  - Record a hit when a write is accepted at edge n and rd_address[p]==wr_address.
  - Register per-byte mask = byteenable (hit only) and register wr_writedata.
  - Output byte i = registered writedata byte i if the mask bit is set, else the array byte.
  - Net effect: the output equals the post-write contents.
- A write at edge n-1 followed by a read at edge n needs no bypass; the array is already updated.
- A read sampled while in CLEARING, including the final clearing cycle, returns 0.
- rd_readdata is registered; no combinational path from inputs to outputs except the bypass mux, which is driven from registers only.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release reset -> wr_waitrequest stays 1 for exactly 16 clk edges, then 0; reads of addresses 0..15 all return 32'h0.
- Write 0xDEADBEEF to address 3 with be=4'hF, then the next cycle read address 3 on both ports -> both return 0xDEADBEEF one cycle after sampling.
- Address 5 holds 0x11223344. In the same cycle, write 0xAABBCCDD with be=4'b0101 and read address 5 on port 0 -> port 0 returns 0x11BB33DD. Port 1 reading address 6 that cycle returns address 6's contents.
- While READY, pulse clear for 1 cycle, with a write to address 2 during the clear -> waitrequest=1 for 16 cycles, the write is dropped, and address 2 reads 0 afterwards.
- Assert reset_n low at clear cycle 7, release 2 cycles later -> a full 16-cycle clear restarts and waitrequest=1 throughout.
- DEPTH=12, ADDR_WIDTH=4: write to address 13 -> addresses 0..11 unchanged; read of address 13 -> 0.
- Random: 2000 cycles of random writes/byteenables/reads on all ports, plus occasional clear, against a reference model -> zero mismatches.
